// File: rtl/rr_mux8way_pkg.sv
// Shared constants for the 8-way round-robin merger.
// Source indices and default data width.
package rr_mux8way_pkg;
    localparam int DATA_W = 16;
    localparam int NSRC   = 8;

    typedef logic [2:0] src_t;

    localparam src_t SRC_A = 3'd0;
    localparam src_t SRC_B = 3'd1;
    localparam src_t SRC_C = 3'd2;
    localparam src_t SRC_D = 3'd3;
    localparam src_t SRC_E = 3'd4;
    localparam src_t SRC_F = 3'd5;
    localparam src_t SRC_G = 3'd6;
    localparam src_t SRC_H = 3'd7;
endpackage

// File: rtl/rr_mux8way_if.sv
// Bundle of the eight source channels and the merged output.
// slave = merger side, master = environment side.
interface rr_mux8way_if
    import rr_mux8way_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [NSRC-1:0]       IN_VALID;
    logic [NSRC*WIDTH-1:0] IN_DATA;
    logic [NSRC-1:0]       IN_READY;
    logic                  OUT_VALID;
    logic [WIDTH-1:0]      OUT_DATA;
    logic [2:0]            OUT_SEL;
    logic                  OUT_READY;

    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_SEL
    );

    modport master (
        output IN_VALID, IN_DATA, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_SEL
    );
endinterface

// File: rtl/rr_mux8way_pick8.sv
// Round-robin winner search: first valid bit at or after ptr,
// wrapping mod 8. win is don't-care when any is low.
module rr_pick8
    import rr_mux8way_pkg::*;
(
    input  logic [7:0] valid,
    input  src_t       ptr,
    output src_t       win,
    output logic       any
);
    src_t idx;
    logic found;

    // Scan from ptr upward; the 3-bit sum wraps naturally.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + src_t'(i);
            if (!found && valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |valid;
endmodule

// File: rtl/rr_mux8way.sv
// 8-to-1 round-robin channel merger with source tag.
// Holds the priority pointer, output register and ready decode.
module rr_mux8way
    import rr_mux8way_pkg::*;
#(
    parameter int WIDTH = DATA_W
)(
    input  logic          CLK,
    input  logic          RESET,
    rr_mux8way_if.slave   bus
);
    src_t             ptr;
    src_t             win;
    logic             any;
    logic             load_en;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    src_t             out_sel;
    logic [WIDTH-1:0] win_data;

    rr_pick8 u_pick (
        .valid (bus.IN_VALID),
        .ptr   (ptr),
        .win   (win),
        .any   (any)
    );

    assign load_en  = !out_valid || bus.OUT_READY;
    assign win_data = bus.IN_DATA[int'(win)*WIDTH +: WIDTH];

    // Grant only the winner, only when the register can take it.
    always_comb begin
        bus.IN_READY = '0;
        if (load_en && any && !RESET)
            bus.IN_READY[win] = 1'b1;
    end

    // Output register and pointer; stall holds everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= SRC_A;
            ptr       <= SRC_A;
        end else if (load_en) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= win;
                ptr       <= win + 3'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = out_data;
    assign bus.OUT_SEL   = out_sel;
endmodule

// File: doc/rr_mux8way.md
Name: rr_mux8way

Overview:
- Sequential 8-to-1 channel merger: collects words from eight independent valid/ready sources and forwards them one per cycle onto a single output channel.
- Arbitration is round-robin.
- The output carries a 3-bit tag identifying the source, so a downstream 8-way router can steer replies back.
- Sits between per-device request sources (keyboard, screen, timers, ...) and the shared memory-mapped bus port.

Parameters:
- WIDTH, 16, data width of each channel (Hack word).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  8  per-source valid; bit i = source i (0=A ... 7=H).
- IN_DATA  input  8*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- IN_READY  output  8  per-source ready; at most one bit set per cycle.
- OUT_VALID  output  1  output register holds a word.
- OUT_DATA  output  WIDTH  forwarded word.
- OUT_SEL  output  3  index of source that supplied OUT_DATA (000=A ... 111=H).
- OUT_READY  input  1  downstream accepts when OUT_VALID & OUT_READY.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - OUT_VALID=0, OUT_DATA=0, OUT_SEL=0.
  - Priority pointer PTR=0 (A highest).
  - IN_READY=0 during the reset cycle.
  - Reset mid-transfer drops the held word; no source sees a handshake in that cycle.
- LOAD_EN = !OUT_VALID | OUT_READY. The register is empty or draining this cycle, so full throughput is 1 word/cycle.
- Arbitration (combinational):
  - Scan IN_VALID starting at PTR, then PTR+1, ... wrapping mod 8.
  - The first set bit is the winner W.
  - Winner is don't-care when IN_VALID==0.
- IN_READY[i] = LOAD_EN & (IN_VALID != 0) & (i == W). IN_READY never depends on OUT_VALID of other sources and never asserts for a non-valid source.
- On an edge with LOAD_EN & any IN_VALID:
  - OUT_DATA <= IN_DATA[W]
  - OUT_SEL <= W
  - OUT_VALID <= 1
  - PTR <= W+1 (mod 8; 7 wraps to 0)
- On an edge with LOAD_EN & IN_VALID==0:
  - OUT_VALID <= 0 (if it was draining).
  - OUT_DATA and OUT_SEL hold their last values.
  - PTR holds.
- On an edge with OUT_VALID & !OUT_READY (stall):
  - All outputs and PTR hold.
  - IN_READY=0.
- Latency: a source word accepted at edge N is visible on OUT_* after edge N; minimum 1 cycle.
- Fairness: a continuously valid source is granted within 8 consecutive grants.
- Source protocol: a source must hold IN_DATA stable while IN_VALID=1 and !IN_READY. The block does not check this.
- OUT_DATA and OUT_SEL are stable while OUT_VALID=1 and OUT_READY=0.

Decomposition:
- Shared package/include: constants for the source indices SRC_A..SRC_H (0..7) and the data width default 16.
- One natural sub-module, rr_pick8: combinational, takes IN_VALID[7:0] and PTR[2:0], returns W[2:0] and ANY.
- Top level holds PTR, the output register and the ready decode.

Test Plan:
- Reset: RESET=1 for 2 cycles with IN_VALID=8'hFF -> IN_READY=0, OUT_VALID=0, OUT_DATA=0, OUT_SEL=0. First grant after release is A (OUT_SEL=0).
- Single source: IN_VALID=8'b0000_0100, IN_DATA for C=16'h1234, OUT_READY=1 -> IN_READY=8'b0000_0100. Next cycle OUT_VALID=1, OUT_DATA=16'h1234, OUT_SEL=2; PTR becomes 3.
- Round-robin wrap: all 8 valid continuously, OUT_READY=1 -> OUT_SEL sequence 0,1,2,...,7,0,1. One word per cycle with no bubbles.
- Backpressure: OUT_VALID=1 with OUT_SEL=5, OUT_DATA=16'hBEEF, then OUT_READY=0 for 4 cycles with sources valid -> IN_READY=0 and outputs hold 16'hBEEF/5. On OUT_READY=1, the next winner starts from source 6.
- Skip idle sources: PTR=6, IN_VALID=8'b0000_0011 -> A granted (wrap past G,H). Then PTR=1 -> B granted next.
- Reset mid-operation: OUT_VALID=1 stalled, assert RESET for 1 cycle -> OUT_VALID=0, PTR=0, no IN_READY pulse. With IN_VALID=8'b1000_0001 after release, A is granted first.
